// File: rtl/output_ring_sequencer_pkg.sv
// Shared types and default widths for the output ring sequencer.
package output_ring_sequencer_pkg;

   typedef enum logic [1:0] {StIdle, StRun, StDone} state_e;

   localparam int unsigned DefElementBits = 8;
   localparam int unsigned DefFeatureBits = 4;

endpackage

// File: rtl/output_ring_sequencer_if.sv
// Ring/cell-buffer bundle: the bench drives the master side, the sequencer is the slave.
interface output_ring_sequencer_if
   import output_ring_sequencer_pkg::*;
#(
   parameter int unsigned ELEMENT_BITS = DefElementBits,
   parameter int unsigned FEATURE_BITS = DefFeatureBits
);

   logic                    start;
   logic                    hold;
   logic [ELEMENT_BITS-1:0] last_pe_data;
   logic [ELEMENT_BITS-1:0] first_pe_data;
   logic                    pe_tick;
   logic                    busy;
   logic                    done;
   logic [ELEMENT_BITS-1:0] cell_wr_data;
   logic [FEATURE_BITS-1:0] cell_wr_addr;
   logic                    cell_we;

   modport master (
      output start, hold, last_pe_data,
      input  first_pe_data, pe_tick, busy, done, cell_wr_data, cell_wr_addr, cell_we
   );

   modport slave (
      input  start, hold, last_pe_data,
      output first_pe_data, pe_tick, busy, done, cell_wr_data, cell_wr_addr, cell_we
   );

endinterface

// File: rtl/output_ring_sequencer_pe_tick_gen.sv
// PE_DIV divider: registered 1-cycle tick in the cycle the count sits at PE_DIV-1.
module output_ring_sequencer_pe_tick_gen #(
   parameter int unsigned PE_DIV = 5
) (
   input  logic clk_i,
   input  logic rst_i,
   input  logic clear_i,
   input  logic hold_i,
   output logic pe_tick_o
);

   localparam int unsigned DivBits = $clog2(PE_DIV);
   localparam logic [DivBits-1:0] DivMax = DivBits'(PE_DIV - 1);

   logic [DivBits-1:0] div_q, div_d;
   logic               tick_q, tick_d;

   always_comb begin
      div_d  = div_q;
      tick_d = 1'b0;
      if (clear_i) begin
         div_d = '0;
      end else if (!hold_i) begin
         div_d  = (div_q == DivMax) ? '0 : div_q + 1'b1;
         // Registered from the next count so the strobe lines up with div==PE_DIV-1.
         tick_d = (div_d == DivMax);
      end
   end

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         div_q  <= '0;
         tick_q <= 1'b0;
      end else begin
         div_q  <= div_d;
         tick_q <= tick_d;
      end
   end

   assign pe_tick_o = tick_q;

endmodule

// File: rtl/output_ring_sequencer.sv
// Output ring controller: recirculates partial sums for P ticks per element and writes
// each finished element of an M-element vector into the cell buffer.
module output_ring_sequencer
   import output_ring_sequencer_pkg::*;
#(
   parameter int unsigned ELEMENT_BITS = DefElementBits,
   parameter int unsigned FEATURE_BITS = DefFeatureBits,
   parameter int unsigned P            = 4,
   parameter int unsigned M            = 9,
   parameter int unsigned PE_DIV       = 5
) (
   input  logic                  sys_clk,
   input  logic                  reset,
   output_ring_sequencer_if.slave bus
);

   localparam int unsigned RingBits = (P > 1) ? $clog2(P) : 1;

   if ((2 ** FEATURE_BITS) < M) begin : g_addr_check
      $error("FEATURE_BITS too narrow to address M elements");
   end

   state_e                  state_q;
   logic [RingBits-1:0]     ring_q;
   logic [FEATURE_BITS-1:0] elem_q;
   logic [ELEMENT_BITS-1:0] first_q;
   logic [ELEMENT_BITS-1:0] wr_data_q;
   logic [FEATURE_BITS-1:0] wr_addr_q;
   logic                    we_q;
   logic                    done_q;
   logic                    pe_tick;

   output_ring_sequencer_pe_tick_gen #(
      .PE_DIV (PE_DIV)
   ) u_tick_gen (
      .clk_i     (sys_clk),
      .rst_i     (reset),
      .clear_i   (state_q != StRun),
      .hold_i    (bus.hold),
      .pe_tick_o (pe_tick)
   );

   always_ff @(posedge sys_clk) begin
      if (reset) begin
         state_q   <= StIdle;
         ring_q    <= '0;
         elem_q    <= '0;
         first_q   <= '0;
         wr_data_q <= '0;
         wr_addr_q <= '0;
         we_q      <= 1'b0;
         done_q    <= 1'b0;
      end else begin
         we_q   <= 1'b0;
         done_q <= 1'b0;
         unique case (state_q)
            StIdle: begin
               if (bus.start) begin
                  state_q <= StRun;
                  ring_q  <= '0;
                  elem_q  <= '0;
                  first_q <= '0;
               end
            end
            StRun: begin
               // The tick is honoured even if hold rises in the tick cycle itself.
               if (pe_tick) begin
                  if (ring_q == RingBits'(P - 1)) begin
                     first_q   <= '0;
                     ring_q    <= '0;
                     wr_data_q <= bus.last_pe_data;
                     wr_addr_q <= elem_q;
                     we_q      <= 1'b1;
                     if (elem_q == FEATURE_BITS'(M - 1)) begin
                        state_q <= StDone;
                        done_q  <= 1'b1;
                     end else begin
                        elem_q <= elem_q + 1'b1;
                     end
                  end else begin
                     first_q <= bus.last_pe_data;
                     ring_q  <= ring_q + 1'b1;
                  end
               end
            end
            StDone:  state_q <= StIdle;
            default: state_q <= StIdle;
         endcase
      end
   end

   assign bus.first_pe_data = first_q;
   assign bus.pe_tick       = pe_tick;
   assign bus.busy          = (state_q == StRun);
   assign bus.done          = done_q;
   assign bus.cell_wr_data  = wr_data_q;
   assign bus.cell_wr_addr  = wr_addr_q;
   assign bus.cell_we       = we_q;

endmodule
